// File: rtl/imem_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader_if: byte-stream handshake plus IMEM write port           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface imem_loader_if #(
  parameter int im_size = 8
);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               imem_we;
  logic [im_size-1:0] imem_addr;
  logic [15:0]        imem_wdata;

  // master: byte source that also observes the IMEM write port
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  // slave: the loader itself
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader: framed byte-stream loader writing 16-bit IMEM words     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_loader #(
  parameter int im_size = 8,
  parameter int TIMEOUT = 1024
) (
  input  wire logic     clk,
  input  wire logic     rst,
  imem_loader_if.slave  bus,
  input  wire logic     go,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    CSUM = 3'd4
  } state_t;

  localparam logic [1:0]     c_ERR_NONE = 2'd0;
  localparam logic [1:0]     c_ERR_CSUM = 2'd1;
  localparam logic [1:0]     c_ERR_TMO  = 2'd2;
  localparam int             c_TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_TLIM    = c_TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             r_state, w_state_nx;
  logic [8:0]         r_count, w_count_nx;
  logic [7:0]         r_xor, w_xor_nx;
  logic [7:0]         r_hi, w_hi_nx;
  logic [im_size-1:0] r_addr, w_addr_nx;
  logic [15:0]        r_wdata, w_wdata_nx;
  logic               r_cpu_rst, w_cpu_rst_nx;
  logic               r_busy, w_busy_nx;
  logic               r_done, w_done_nx;
  logic [1:0]         r_err, w_err_nx;
  logic [c_TW-1:0]    r_tcnt, w_tcnt_nx;
  logic               w_xfer;
  logic               w_waiting;

  assign bus.rx_ready   = (r_state != WR);
  assign bus.imem_we    = (r_state == WR);
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign cpu_rst        = r_cpu_rst;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;

  assign w_xfer    = bus.rx_valid && bus.rx_ready;
  assign w_waiting = ((r_state == HI) || (r_state == LO) || (r_state == CSUM)) && !w_xfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_xor     <= '0;
      r_hi      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cpu_rst <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= c_ERR_NONE;
      r_tcnt    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= w_count_nx;
      r_xor     <= w_xor_nx;
      r_hi      <= w_hi_nx;
      r_addr    <= w_addr_nx;
      r_wdata   <= w_wdata_nx;
      r_cpu_rst <= w_cpu_rst_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
      r_tcnt    <= w_tcnt_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_count_nx   = r_count;
    w_xor_nx     = r_xor;
    w_hi_nx      = r_hi;
    w_addr_nx    = r_addr;
    w_wdata_nx   = r_wdata;
    w_cpu_rst_nx = r_cpu_rst;
    w_busy_nx    = r_busy;
    w_done_nx    = r_done;
    w_err_nx     = r_err;
    w_tcnt_nx    = '0;

    case (r_state)
      IDLE: begin
        // A header beats a coincident go, so the CPU stays in reset.
        if (w_xfer) begin
          w_count_nx   = {(bus.rx_data == 8'd0), bus.rx_data};
          w_xor_nx     = bus.rx_data;
          w_addr_nx    = '0;
          w_cpu_rst_nx = 1'b1;
          w_busy_nx    = 1'b1;
          w_done_nx    = 1'b0;
          w_err_nx     = c_ERR_NONE;
          w_state_nx   = HI;
        end else if (go) begin
          w_cpu_rst_nx = 1'b0;
        end
      end
      HI: begin
        if (w_xfer) begin
          w_hi_nx    = bus.rx_data;
          w_xor_nx   = r_xor ^ bus.rx_data;
          w_state_nx = LO;
        end
      end
      LO: begin
        if (w_xfer) begin
          w_wdata_nx = {r_hi, bus.rx_data};
          w_xor_nx   = r_xor ^ bus.rx_data;
          w_state_nx = WR;
        end
      end
      WR: begin
        w_addr_nx  = r_addr + im_size'(1);
        w_count_nx = r_count - 9'd1;
        w_state_nx = (r_count == 9'd1) ? CSUM : HI;
      end
      CSUM: begin
        if (w_xfer) begin
          if ((r_xor ^ bus.rx_data) == 8'd0) begin
            w_done_nx    = 1'b1;
            w_cpu_rst_nx = 1'b0;
          end else begin
            w_err_nx = c_ERR_CSUM;
          end
          w_busy_nx  = 1'b0;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // Stall watchdog: only byte-waiting states count idle cycles.
    if ((TIMEOUT != 0) && w_waiting) begin
      if (r_tcnt == c_TLIM) begin
        w_state_nx = IDLE;
        w_err_nx   = c_ERR_TMO;
        w_busy_nx  = 1'b0;
      end else begin
        w_tcnt_nx = r_tcnt + c_TW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader: scoreboard bench with a frame-level reference model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imem_loader;

  localparam int IMS   = 2;
  localparam int TMO   = 16;
  localparam int DEPTH = 1 << IMS;

  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       go  = 1'b0;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic [1:0] err;

  imem_loader_if #(.im_size(IMS)) bus ();

  imem_loader #(.im_size(IMS), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .go      (go),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  wr_t         exp_q[$];
  logic [7:0]  frame_q[$];
  logic [15:0] mem [DEPTH];
  int          checks  = 0;
  int          errors  = 0;
  int          rdy_low = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every IMEM write is matched against the scoreboard queue.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst) begin
      if (!bus.rx_ready) rdy_low++;
      if (bus.imem_we) begin
        chk("we_with_ready_low", bus.rx_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", bus.imem_addr, e.addr);
          chk("write_data", bus.imem_wdata, e.data);
        end
        mem[bus.imem_addr] = bus.imem_wdata;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) chk("ready_wait", 0, 1);
    @(negedge clk);
  endtask

  function automatic void append_csum();
    logic [7:0] x = 8'h00;
    foreach (frame_q[i]) x ^= frame_q[i];
    frame_q.push_back(x);
  endfunction

  // Reference model: a frame is N words of {hi,lo} at addr i mod DEPTH,
  // good iff the XOR of every byte is zero. go_mode: 1 = go with header,
  // 2 = go pulse while waiting for the first data byte.
  task automatic send_frame(input int gap_max, input int go_mode);
    int         n;
    logic [7:0] x = 8'h00;
    bit         good;
    wr_t        w;
    n = (frame_q[0] == 8'h00) ? 256 : int'(frame_q[0]);
    foreach (frame_q[i]) x ^= frame_q[i];
    good = (x == 8'h00);
    for (int i = 0; i < n; i++) begin
      w.addr = i % DEPTH;
      w.data = {frame_q[1 + 2 * i], frame_q[2 + 2 * i]};
      exp_q.push_back(w);
    end
    rdy_low = 0;
    if (go_mode == 1) go = 1'b1;
    send_byte(frame_q[0]);
    go = 1'b0;
    if (go_mode == 2) begin
      bus.rx_valid = 1'b0;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    if (go_mode != 0) begin
      chk("go_held_cpu_rst", cpu_rst, 1);
      chk("go_held_busy", busy, 1);
    end
    for (int i = 1; i < frame_q.size(); i++) begin
      if (gap_max > 0) begin
        bus.rx_valid = 1'b0;
        repeat ($urandom_range(gap_max)) @(negedge clk);
      end
      send_byte(frame_q[i]);
    end
    bus.rx_valid = 1'b0;
    chk("frame_done", done, good);
    chk("frame_err", err, good ? 0 : 1);
    chk("frame_cpu_rst", cpu_rst, !good);
    chk("frame_busy", busy, 0);
    chk("writes_pending", exp_q.size(), 0);
    chk("ready_low_cycles", rdy_low, n);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"}, bus.rx_ready, 1);
    chk({tag, "_imem_we"}, bus.imem_we, 0);
    chk({tag, "_imem_addr"}, bus.imem_addr, 0);
    chk({tag, "_imem_wdata"}, bus.imem_wdata, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    wr_t w;
    int  n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);

    // go straight after reset releases the CPU
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("go_after_reset", cpu_rst, 0);

    // Good two-word load, valid held high
    frame_q = '{8'h02, 8'h10, 8'h05, 8'h10, 8'h17, 8'h10};
    send_frame(0, 0);
    chk("good_mem0", mem[0], 16'h1005);
    chk("good_mem1", mem[1], 16'h1017);

    // Bad checksum, then go
    frame_q = '{8'h02, 8'h10, 8'h05, 8'h10, 8'h17, 8'h11};
    send_frame(0, 0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("go_after_bad", cpu_rst, 0);

    // Timeout after header and high byte
    send_byte(8'h01);
    send_byte(8'h12);
    bus.rx_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("tmo_busy_before", busy, 1);
    chk("tmo_err_before", err, 0);
    @(negedge clk);
    chk("tmo_err", err, 2);
    chk("tmo_busy", busy, 0);
    chk("tmo_cpu_rst", cpu_rst, 1);
    repeat (3) @(negedge clk);
    frame_q = '{8'h01, 8'hAB, 8'hCD};
    append_csum();
    send_frame(0, 0);

    // Address wrap with 4-word IMEM
    frame_q = '{8'h05, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
                8'h00, 8'h04, 8'h00, 8'h05, 8'h04};
    send_frame(0, 0);
    chk("wrap_mem0", mem[0], 16'h0005);
    chk("wrap_mem3", mem[3], 16'h0004);

    // Reset after three bytes of a two-word frame
    w.addr = 0;
    w.data = 16'h3344;
    exp_q.push_back(w);
    send_byte(8'h02);
    send_byte(8'h33);
    send_byte(8'h44);
    bus.rx_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_values("midreset");
    chk("midreset_write_seen", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    frame_q = '{8'h02, 8'h55, 8'h66, 8'h77, 8'h88};
    append_csum();
    send_frame(0, 0);
    chk("after_reset_mem0", mem[0], 16'h5566);

    // go while busy, then go coincident with a header
    frame_q = '{8'h01, 8'h12, 8'h34};
    append_csum();
    send_frame(0, 2);
    frame_q = '{8'h01, 8'h9A, 8'hBC};
    append_csum();
    send_frame(0, 1);

    // Randomized frames with gaps and occasional bad checksums
    repeat (20) begin
      n = $urandom_range(9, 1);
      frame_q = {};
      frame_q.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) frame_q.push_back(8'($urandom_range(255)));
      append_csum();
      if ($urandom_range(3) == 0)
        frame_q[frame_q.size() - 1] ^= 8'($urandom_range(255, 1));
      send_frame(6, 0);
    end

    // Header 0 means 256 words
    frame_q = {};
    frame_q.push_back(8'h00);
    for (int i = 0; i < 512; i++) frame_q.push_back(8'($urandom_range(255)));
    append_csum();
    send_frame(0, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader. It is the writer side of the CPU instruction memory, which the processor core only ever reads.
- It accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words (opcode + 3×4-bit fields).
- Each word is written sequentially into IMEM from address 0.
- The CPU core is held in reset while loading and is released only after a verified load or an explicit go.

Parameters:
- im_size, 8, IMEM address width; 2**im_size words.
- TIMEOUT, 1024, idle cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte.
- go  input  1  single-cycle pulse; releases the CPU without loading.
- imem_we  output  1  IMEM write strobe, one cycle per word.
- imem_addr  output  im_size  IMEM write address.
- imem_wdata  output  16  IMEM write data, {high byte, low byte}.
- cpu_rst  output  1  active-high reset to the CPU core.
- busy  output  1  frame in progress.
- done  output  1  sticky: last frame loaded with a good checksum.
- err  output  2  sticky: 0 = none, 1 = checksum mismatch, 2 = timeout.

Behaviour:
- Reset (rst=0, asynchronous) drives these values: state=IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0; byte count, XOR accumulator and timeout counter all 0.
- Transfer rule: a byte transfers on a rising edge where rx_valid && rx_ready. rx_data is ignored at all other times.
- Frame format, in order:
  - header byte N = word count, where N=0 means 256;
  - 2N data bytes, high byte of each word first;
  - 1 checksum byte.
- A frame is good when the XOR of the header, all data bytes and the checksum equals 0x00.
- States:
  - IDLE: rx_ready=1, busy=0. A header transfer loads count=N (0→256), sets xor=N, imem_addr=0, cpu_rst=1, busy=1, and clears done and err. Next state HI.
  - HI: rx_ready=1. A transfer latches the high byte and XORs it into xor. Next state LO.
  - LO: rx_ready=1. A transfer drives imem_wdata={hi,byte} and XORs the byte into xor. Next state WR.
  - WR: rx_ready=0; imem_we=1 for exactly this cycle, with imem_addr and imem_wdata stable. On the edge that leaves WR:
    - imem_addr increments, wrapping modulo 2**im_size when N > 2**im_size;
    - count decrements;
    - next state is CSUM if count was 1, else HI.
  - CSUM: rx_ready=1. On transfer, if (xor ^ byte)==0: done=1, cpu_rst=0 on the next cycle. Otherwise err=1 and cpu_rst stays 1. Either way, next state IDLE with busy=0.
- Throughput: one byte per cycle, plus one bubble cycle (WR) per word. The latency from LO transfer to imem_we is exactly 1 cycle.
- Timeout (TIMEOUT>0):
  - The counter runs in HI, LO and CSUM, and clears on every transfer and on entry to those states.
  - When it reaches TIMEOUT: next state IDLE, err=2, busy=0, cpu_rst stays 1, and no further writes occur.
  - WR does not count.
- go:
  - Honoured only in IDLE: cpu_rst=0 on the next cycle.
  - go while busy is ignored.
  - go together with a header transfer in the same cycle: the header wins and cpu_rst stays 1.
- A CPU that has been released is returned to reset by the next header transfer.
- Reset mid-frame: the frame is abandoned immediately and outputs take their reset values. Words already written stay in IMEM; the loader does not clear them.
- imem_we is never asserted outside WR.

Test Plan:
- Good load of 2 words. Stream 02,10,05,10,17,10 with rx_valid held high.
  - Required: imem_we at addr 0 data 0x1005, then at addr 1 data 0x1017.
  - rx_ready low exactly 2 single cycles.
  - Then done=1, err=0, cpu_rst=0.
- Bad checksum. Same stream ending with 0x11.
  - Required: both writes occur, err=1, done=0, cpu_rst=1.
  - go afterwards then gives cpu_rst=0.
- Timeout (TIMEOUT=16). Send 01,12, then hold rx_valid=0.
  - Required: 16 cycles later err=2, busy=0, no imem_we, cpu_rst=1.
  - The next byte is treated as a header.
- Wrap with im_size=2. Frame N=5 with words 0x0001..0x0005.
  - Required: write addresses 0,1,2,3,0; final IMEM[0]=0x0005.
- Reset mid-frame. Assert rst=0 after 3 bytes of a 2-word frame.
  - Required: outputs immediately take reset values.
  - A subsequent good frame writes starting from addr 0.
- go behaviour.
  - go pulse right after reset: cpu_rst falls next cycle.
  - go during HI: ignored.
  - go coincident with a header: cpu_rst=1.
